board_renderer: RTL and testbench
=================================

BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 24, giving the tile edge in pixels.
REQ-002 SHALL have parameter X0, default 32, giving the board left edge in pixels.
REQ-003 SHALL have parameter Y0, default 12, giving the board top edge in pixels.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port blockState, input, 64 bits: tile i (0..15) is bits [4i+3:4i]; value 0 means the empty slot.
REQ-007 SHALL have port ifWin, input, 1 bit: the board is solved.
REQ-008 SHALL have port xOut, output, 8 bits: pixel x coordinate.
REQ-009 SHALL have port yOut, output, 7 bits: pixel y coordinate.
REQ-010 SHALL have port colourOut, output, 3 bits: pixel colour as RGB.
REQ-011 SHALL have port plot, output, 1 bit: write strobe to the VGA adapter.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-014 SHALL draw a 4x4 grid; tile i is at row i/4, col i%4, and tile 0 is top-left.
REQ-015 SHALL implement FSM states IDLE, LOAD, DRAW and DONE.
REQ-016 SHALL take the IDLE->LOAD transition when pending=1.
REQ-017 SHALL take the LOAD->DRAW transition unconditionally, after one cycle.
REQ-018 SHALL take the DRAW->DONE transition after the last pixel.
REQ-019 SHALL take the DONE->IDLE transition unconditionally, after one cycle.
REQ-020 SHALL compare blockState and ifWin against the snapshot registers every cycle, in every state, and set pending on any difference at the next edge.
REQ-021 SHALL in LOAD copy blockState and ifWin into the snapshot registers, clear pending, and zero the tile, px and py counters.
REQ-022 SHALL render from the snapshot only; input changes during DRAW set pending and do not alter the frame in progress.
REQ-023 SHALL in DRAW emit one pixel per cycle in tile order 0..15; within a tile, rows py from 0 to TILE_SIZE-1, then columns px from 0 to TILE_SIZE-1.
REQ-024 SHALL drive xOut = X0 + col*TILE_SIZE + px and yOut = Y0 + row*TILE_SIZE + py, truncated to 8 and 7 bits respectively; the defaults peak at x=127 and y=107 with no overflow.
REQ-025 SHALL draw a tile of value 0 with every pixel colour 3'b000.
REQ-026 SHALL draw a nonzero tile's border pixels (px or py equal to 0 or TILE_SIZE-1) as 3'b111, or as 3'b010 when the snapshot ifWin=1.
REQ-027 SHALL draw a nonzero tile's interior pixels as PALETTE[value].
REQ-028 SHALL drive plot=1 only in DRAW, with exactly 16*TILE_SIZE^2 plot cycles per frame (9216 at defaults).
REQ-029 SHALL drive xOut, yOut and colourOut combinationally from the counters and snapshot, and hold them at 0 outside DRAW.
REQ-030 SHALL drive busy = (state != IDLE).
REQ-031 SHALL assert done only in DONE.
REQ-032 SHALL, when pending is set again during DRAW, complete the current frame, go DONE->IDLE, and then start a new frame immediately.
REQ-033 SHALL start at most one extra frame, however many changes occur during a frame.

Reset
REQ-034 SHALL on resetn=0 immediately force state=IDLE, zero the counters, and drive plot=0, busy=0, done=0, xOut=0, yOut=0 and colourOut=0.
REQ-035 SHALL on resetn=0 clear the snapshot to 0 and set pending=1, so one full frame is drawn after reset without any input change.
REQ-036 SHALL abandon a frame in progress when reset asserts mid-frame; no further plot occurs until the redraw after reset.

Structure
REQ-037 SHALL place TILE_SIZE, X0 and Y0 defaults, the state encoding, and the 16-entry PALETTE in shared package gameboard_pkg.
REQ-038 SHALL define PALETTE as: 0 maps to 000, 8 maps to 110, 15 maps to 101, and every other value v maps to v[2:0].
REQ-039 SHALL implement the tile/px/py counting in one sub-module, board_scan_counter, with inputs clear and enable and outputs tile[3:0], px, py and last.
REQ-040 SHALL keep the FSM, change detection and colour selection in board_renderer.

Verification
REQ-041 SHALL verify reset-to-frame: release reset with blockState = solved (tile i = i+1, tile 15 = 0) -> the first plot is at (32,12), the last at (127,107), done pulses on the cycle after the last plot, and the plot count is 9216.
REQ-042 SHALL verify win colouring: ifWin=1 with the solved board -> pixel (32,12) is 010 and pixel (44,24) is PALETTE[1]=001.
REQ-043 SHALL verify the empty tile: tile 15 = 0 -> every pixel in x 104..127, y 84..107 has colour 000.
REQ-044 SHALL verify a mid-frame change: swap tiles 14 and 15 at plot 4000 -> the first frame completes unchanged, one done pulse, then a second frame of 9216 plots reflecting the swap, then idle.
REQ-045 SHALL verify reset mid-frame: assert resetn=0 at plot 100 -> plot, busy and the outputs are 0 in the same cycle; after release a full 9216-plot frame follows.
REQ-046 SHALL verify no change, no redraw: after a frame, hold the inputs constant for 20000 cycles -> busy stays 0 and plot stays 0.

Source files
------------

// File: rtl/gameboard_pkg.sv
// Shared board geometry defaults, renderer state encoding and tile colour palette.
package gameboard_pkg;

  localparam int TILE_SIZE_DEFAULT = 24;
  localparam int X0_DEFAULT        = 32;
  localparam int Y0_DEFAULT        = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } render_state_t;

  // Entry v is the interior colour of a tile holding value v (RGB, 3 bits).
  // Most values show their low three bits; 0, 8 and 15 are special cased so
  // the empty slot is black and 8/15 do not collide with 0/7.
  localparam logic [15:0][2:0] PALETTE = {
    3'b101,  // 15
    3'b110,  // 14
    3'b101,  // 13
    3'b100,  // 12
    3'b011,  // 11
    3'b010,  // 10
    3'b001,  // 9
    3'b110,  // 8
    3'b111,  // 7
    3'b110,  // 6
    3'b101,  // 5
    3'b100,  // 4
    3'b011,  // 3
    3'b010,  // 2
    3'b001,  // 1
    3'b000   // 0
  };

endpackage

// File: rtl/board_scan_counter.sv
// Walks tile 0..15 and, inside each tile, every pixel row by row (px fastest).
module board_scan_counter
  import gameboard_pkg::*;
#(
  parameter int TILE_SIZE = TILE_SIZE_DEFAULT,
  parameter int CW        = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          enable,
  output logic [3:0]    tile,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          last
);

  localparam logic [CW-1:0] EDGE = CW'(TILE_SIZE - 1);

  // Advance px each enabled cycle, carrying into py and then into tile.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tile <= '0;
      px   <= '0;
      py   <= '0;
    end else if (clear) begin
      tile <= '0;
      px   <= '0;
      py   <= '0;
    end else if (enable) begin
      if (px == EDGE) begin
        px <= '0;
        if (py == EDGE) begin
          py   <= '0;
          tile <= tile + 4'd1;
        end else begin
          py <= py + 1'b1;
        end
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  assign last = (tile == 4'd15) && (px == EDGE) && (py == EDGE);

endmodule

// File: rtl/board_renderer.sv
// Redraws the 4x4 puzzle board into a VGA adapter whenever the board or win flag changes.
module board_renderer
  import gameboard_pkg::*;
#(
  parameter int TILE_SIZE = TILE_SIZE_DEFAULT,
  parameter int X0        = X0_DEFAULT,
  parameter int Y0        = Y0_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [63:0] blockState,
  input  logic        ifWin,
  output logic [7:0]  xOut,
  output logic [6:0]  yOut,
  output logic [2:0]  colourOut,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int CW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [CW-1:0] EDGE = CW'(TILE_SIZE - 1);

  render_state_t state, next_state;

  logic [63:0]   snap_state;
  logic          snap_win;
  logic          pending;
  logic          input_changed;

  logic [3:0]    tile;
  logic [CW-1:0] px;
  logic [CW-1:0] py;
  logic          scan_last;

  logic [3:0]    tile_value;
  logic          on_border;
  logic [2:0]    pixel_colour;
  logic [7:0]    pixel_x;
  logic [6:0]    pixel_y;

  board_scan_counter #(
    .TILE_SIZE (TILE_SIZE),
    .CW        (CW)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == LOAD),
    .enable (state == DRAW),
    .tile   (tile),
    .px     (px),
    .py     (py),
    .last   (scan_last)
  );

  assign input_changed = (blockState != snap_state) || (ifWin != snap_win);

  // Pixel geometry and colour come from the snapshot so a frame is never torn.
  assign tile_value = snap_state[{tile, 2'b00} +: 4];
  assign on_border  = (px == '0) || (py == '0) || (px == EDGE) || (py == EDGE);
  assign pixel_x    = 8'(X0) + 8'(tile[1:0]) * 8'(TILE_SIZE) + 8'(px);
  assign pixel_y    = 7'(Y0) + 7'(tile[3:2]) * 7'(TILE_SIZE) + 7'(py);

  // Empty slot is black; otherwise border (green on win) around a palette fill.
  always_comb begin
    pixel_colour = 3'b000;
    if (tile_value != 4'd0) begin
      if (on_border) pixel_colour = snap_win ? 3'b010 : 3'b111;
      else           pixel_colour = PALETTE[tile_value];
    end
  end

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Snapshot and pending flag; reset forces one redraw, LOAD consumes the request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_state <= '0;
      snap_win   <= 1'b0;
      pending    <= 1'b1;
    end else if (state == LOAD) begin
      snap_state <= blockState;
      snap_win   <= ifWin;
      pending    <= 1'b0;
    end else if (input_changed) begin
      pending <= 1'b1;
    end
  end

  // Next-state logic: a pending request launches exactly one frame at a time.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending) next_state = LOAD;
      LOAD:    next_state = DRAW;
      DRAW:    if (scan_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: pixel bus is live only while drawing, zero otherwise.
  always_comb begin
    plot      = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    xOut      = 8'd0;
    yOut      = 7'd0;
    colourOut = 3'b000;
    case (state)
      DRAW: begin
        plot      = 1'b1;
        xOut      = pixel_x;
        yOut      = pixel_y;
        colourOut = pixel_colour;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer against a per-pixel reference model.
module tb_board_renderer;

  localparam int TS     = 24;
  localparam int NPIX   = 16 * TS * TS;

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] blockState;
  logic        ifWin;
  logic [7:0]  xOut;
  logic [6:0]  yOut;
  logic [2:0]  colourOut;
  logic        plot;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [2:0]  fr [0:255][0:127];

  logic [63:0] solved;
  logic [63:0] swapped;
  logic [63:0] rand_board;
  logic        rand_win;

  board_renderer dut (
    .clk        (clk),
    .resetn     (resetn),
    .blockState (blockState),
    .ifWin      (ifWin),
    .xOut       (xOut),
    .yOut       (yOut),
    .colourOut  (colourOut),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison, counted and reported on failure.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Interior colour rule for a tile value.
  function automatic logic [2:0] ref_palette(input logic [3:0] v);
    if (v == 4'd0)       return 3'b000;
    else if (v == 4'd8)  return 3'b110;
    else if (v == 4'd15) return 3'b101;
    else                 return v[2:0];
  endfunction

  // Expected k-th pixel of a frame drawn from board bs with win flag.
  task automatic ref_pixel(input int k, input logic [63:0] bs, input logic win,
                           output logic [7:0] x, output logic [6:0] y, output logic [2:0] c);
    int t, w, ppx, ppy;
    logic [3:0] v;
    t   = k / (TS * TS);
    w   = k % (TS * TS);
    ppy = w / TS;
    ppx = w % TS;
    v   = bs[4*t +: 4];
    x   = 8'(32 + (t % 4) * TS + ppx);
    y   = 7'(12 + (t / 4) * TS + ppy);
    if (v == 4'd0)
      c = 3'b000;
    else if (ppx == 0 || ppy == 0 || ppx == TS - 1 || ppy == TS - 1)
      c = win ? 3'b010 : 3'b111;
    else
      c = ref_palette(v);
  endtask

  // Watch one whole frame, optionally changing blockState after change_at plots.
  task automatic capture_frame(input logic [63:0] bs, input logic win, input int change_at,
                               input logic [63:0] new_bs, input string tag);
    int k, mism, last_cyc, done_cyc;
    logic [7:0] ex, fx, lx;
    logic [6:0] ey, fy, ly;
    logic [2:0] ec;
    string bad;
    k = 0; mism = 0; last_cyc = -1; done_cyc = -1;
    fx = 0; fy = 0; lx = 0; ly = 0; bad = "";
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 128; y++)
        fr[x][y] = 3'bxxx;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        if (k < NPIX) begin
          ref_pixel(k, bs, win, ex, ey, ec);
          if (xOut !== ex || yOut !== ey || colourOut !== ec) begin
            if (mism == 0)
              bad = $sformatf("#%0d got (%0d,%0d,%03b) want (%0d,%0d,%03b)",
                              k, xOut, yOut, colourOut, ex, ey, ec);
            mism++;
          end
        end
        if (k == 0) begin fx = xOut; fy = yOut; end
        lx = xOut; ly = yOut;
        fr[xOut][yOut] = colourOut;
        last_cyc = cyc;
        k++;
        if (k == change_at) blockState = new_bs;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_plots"}, k, NPIX);
    check({tag, "_first_x"}, fx, 32);
    check({tag, "_first_y"}, fy, 12);
    check({tag, "_last_x"}, lx, 127);
    check({tag, "_last_y"}, ly, 107);
    check({tag, "_done_latency"}, done_cyc - last_cyc, 1);
    checks++;
    assert (mism === 0) else begin
      errors++;
      $error("[TB] FAIL %s_pixels mismatches=%0d expected=0 first %s", tag, mism, bad);
    end
    @(negedge clk);
    check({tag, "_done_pulse_width"}, done, 1'b0);
  endtask

  initial begin
    int n, busy_hi, plot_hi, bad_empty;
    for (int i = 0; i < 16; i++) solved[4*i +: 4] = 4'(i + 1);
    solved[63:60] = 4'd0;
    swapped = solved;
    swapped[59:56] = 4'd0;
    swapped[63:60] = 4'd15;

    // Reset state
    resetn = 1'b0;
    blockState = solved;
    ifWin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", xOut, 0);
    check("rst_y", yOut, 0);
    check("rst_colour", colourOut, 0);
    $display("[TB] releasing reset with solved board");
    resetn = 1'b1;

    // Frame drawn straight after reset
    capture_frame(solved, 1'b0, -1, solved, "reset_frame");
    bad_empty = 0;
    for (int x = 104; x <= 127; x++)
      for (int y = 84; y <= 107; y++)
        if (fr[x][y] !== 3'b000) bad_empty++;
    check("empty_tile_nonblack", bad_empty, 0);

    // Win colouring
    ifWin = 1'b1;
    capture_frame(solved, 1'b1, -1, solved, "win_frame");
    check("win_border_32_12", fr[32][12], 3'b010);
    check("win_interior_44_24", fr[44][24], 3'b001);

    // Mid-frame change: first frame unchanged, then exactly one redraw
    ifWin = 1'b0;
    capture_frame(solved, 1'b0, 4000, swapped, "mid_first");
    capture_frame(swapped, 1'b0, -1, swapped, "mid_second");

    // No change, no redraw
    busy_hi = 0; plot_hi = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hi++;
      if (plot !== 1'b0) plot_hi++;
    end
    check("idle_busy_cycles", busy_hi, 0);
    check("idle_plot_cycles", plot_hi, 0);

    // Reset mid-frame on a random board
    begin
      logic [3:0] perm [16];
      logic [3:0] tmp;
      int j;
      for (int i = 0; i < 16; i++) perm[i] = 4'(i);
      for (int i = 15; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < 16; i++) rand_board[4*i +: 4] = perm[i];
      rand_win = 1'($urandom_range(1, 0));
      if (rand_board == swapped) rand_win = 1'b1;
    end
    blockState = rand_board;
    ifWin = rand_win;
    n = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (plot === 1'b1) n++;
      if (n == 100) break;
    end
    check("midrst_plots_before", n, 100);
    resetn = 1'b0;
    #1;
    check("midrst_plot", plot, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_x", xOut, 0);
    check("midrst_y", yOut, 0);
    check("midrst_colour", colourOut, 0);
    @(negedge clk);
    check("midrst_plot_held", plot, 0);
    resetn = 1'b1;
    capture_frame(rand_board, rand_win, -1, rand_board, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
